// File: rtl/r_asym_pkg.sv
// Shared width derivation, byte-address helpers and port-B operation encoding for r_asym_stream_buf.
package r_asym_pkg;

  function automatic int unsigned calc_aw(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned calc_lb(input int unsigned word_bytes);
    return $clog2(word_bytes);
  endfunction

  function automatic int unsigned calc_bw(input int unsigned words, input int unsigned word_bytes);
    return calc_aw(words) + calc_lb(word_bytes);
  endfunction

  // True when the lane index of a byte address selects bank idx.
  function automatic logic lane_hit(input int unsigned lane, input int unsigned idx);
    return lane == idx;
  endfunction

  // Port-B operations in priority order: load beats write beats read.
  typedef enum logic [1:0] {
    BOpNone  = 2'd0,
    BOpLoad  = 2'd1,
    BOpWrite = 2'd2,
    BOpRead  = 2'd3
  } b_op_e;

  function automatic b_op_e b_op_decode(input logic load, input logic wen, input logic ren);
    if (load) return BOpLoad;
    if (wen)  return BOpWrite;
    if (ren)  return BOpRead;
    return BOpNone;
  endfunction

endpackage

// File: rtl/r_asym_lane.sv
// One byte-wide bank of the asymmetric buffer: word-side port and byte-side port, both
// read-before-write, registered read data cleared by synchronous reset.
module r_asym_lane
  import r_asym_pkg::*;
#(
  parameter int unsigned WORDS = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [calc_aw(WORDS)-1:0]  a_addr,
  input  logic                       a_we,
  input  logic [7:0]                 a_wdata,
  input  logic                       a_re,
  output logic [7:0]                 a_rdata,
  input  logic [calc_aw(WORDS)-1:0]  b_addr,
  input  logic                       b_we,
  input  logic [7:0]                 b_wdata,
  input  logic                       b_re,
  output logic [7:0]                 b_rdata
);

  logic [7:0] mem [WORDS];

  // Port A is written last so it wins if both ports ever target one entry.
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_wdata;
    if (a_we) mem[a_addr] <= a_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_re) a_rdata <= mem[a_addr];
      if (b_re) b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/r_asym_stream_buf.sv
// Asymmetric buffer: random-access word port A, auto-incrementing byte-stream port B.
// Optional same-byte conflict reporting on Collision when R_ASYM_COLLISION_DET_EN is defined.
module r_asym_stream_buf
  import r_asym_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned WORDS      = 512
) (
  input  logic                                     Clk,
  input  logic                                     Rst_N,
  input  logic [calc_aw(WORDS)-1:0]                A_Addr,
  input  logic [8*WORD_BYTES-1:0]                  A_WData,
  input  logic [WORD_BYTES-1:0]                    A_WEn,
  input  logic                                     A_REn,
  output logic [8*WORD_BYTES-1:0]                  A_RData,
  output logic                                     A_RValid,
  input  logic                                     B_Load,
  input  logic [calc_bw(WORDS, WORD_BYTES)-1:0]    B_LoadAddr,
  input  logic                                     B_WEn,
  input  logic [7:0]                               B_WData,
  input  logic                                     B_REn,
  output logic [7:0]                               B_RData,
  output logic                                     B_RValid,
  output logic [calc_bw(WORDS, WORD_BYTES)-1:0]    B_Ptr,
  output logic                                     B_Wrap
`ifdef R_ASYM_COLLISION_DET_EN
  ,
  output logic                                     Collision
`endif
);

  localparam int unsigned AW = calc_aw(WORDS);
  localparam int unsigned LB = calc_lb(WORD_BYTES);
  localparam int unsigned BW = AW + LB;
  localparam int unsigned LW = (LB == 0) ? 1 : LB;

  b_op_e             b_op;
  logic [BW-1:0]     ptr_q, ptr_d;
  logic              wrap_q, wrap_d;
  logic              a_rvalid_q, b_rvalid_q;
  logic [LW-1:0]     b_lane, b_lane_q;
  logic [AW-1:0]     b_word;
  logic              b_wr, b_rd, a_re, same_word;
  logic [WORD_BYTES-1:0] a_we_lane, b_we_lane, b_hit;
  logic [7:0]        b_rdata_lane [WORD_BYTES];

  // Requests are ignored while reset is held.
  assign b_op      = Rst_N ? b_op_decode(B_Load, B_WEn, B_REn) : BOpNone;
  assign b_wr      = (b_op == BOpWrite);
  assign b_rd      = (b_op == BOpRead);
  assign a_re      = A_REn & Rst_N;
  assign a_we_lane = A_WEn & {WORD_BYTES{Rst_N}};

  assign b_word    = ptr_q[BW-1:LB];
  assign same_word = (A_Addr == b_word);

  if (LB == 0) begin : g_single_lane
    assign b_lane = 1'b0;
  end else begin : g_multi_lane
    assign b_lane = ptr_q[LW-1:0];
  end

  always_comb begin
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      b_hit[i] = lane_hit(32'(b_lane), i);
      // A port A write to the same byte takes precedence; the B byte is dropped.
      b_we_lane[i] = b_wr & b_hit[i] & ~(a_we_lane[i] & same_word);
    end
  end

  for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
    r_asym_lane #(
      .WORDS(WORDS)
    ) u_lane (
      .clk    (Clk),
      .rst_n  (Rst_N),
      .a_addr (A_Addr),
      .a_we   (a_we_lane[i]),
      .a_wdata(A_WData[8*i +: 8]),
      .a_re   (a_re),
      .a_rdata(A_RData[8*i +: 8]),
      .b_addr (b_word),
      .b_we   (b_we_lane[i]),
      .b_wdata(B_WData),
      .b_re   (b_rd),
      .b_rdata(b_rdata_lane[i])
    );
  end

  always_comb begin
    ptr_d  = ptr_q;
    wrap_d = wrap_q;
    unique case (b_op)
      BOpLoad: begin
        ptr_d  = B_LoadAddr;
        wrap_d = 1'b0;
      end
      BOpWrite, BOpRead: begin
        ptr_d = ptr_q + BW'(1);
        if (ptr_q == '1) wrap_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_N) begin
      ptr_q      <= '0;
      wrap_q     <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      b_lane_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wrap_q     <= wrap_d;
      a_rvalid_q <= a_re;
      b_rvalid_q <= b_rd;
      if (b_rd) b_lane_q <= b_lane;
    end
  end

  always_comb begin
    B_RData = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (lane_hit(32'(b_lane_q), i)) B_RData = b_rdata_lane[i];
    end
  end

  // Valids are masked by reset so a read issued just before reset never surfaces.
  assign A_RValid = a_rvalid_q & Rst_N;
  assign B_RValid = b_rvalid_q & Rst_N;
  assign B_Ptr    = ptr_q;
  assign B_Wrap   = wrap_q;

`ifdef R_ASYM_COLLISION_DET_EN
  logic conflict, collision_q;

  always_comb begin
    conflict = 1'b0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (b_hit[i] && same_word &&
          ((a_we_lane[i] && (b_wr || b_rd)) || (a_re && b_wr))) begin
        conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_N) collision_q <= 1'b0;
    else        collision_q <= conflict;
  end

  assign Collision = collision_q & Rst_N;
`endif

endmodule

// File: tb/tb_r_asym_stream_buf.sv
// Directed bench for r_asym_stream_buf: default 4x512 instance plus a 2x8 instance.
module tb_r_asym_stream_buf;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Default instance: WORD_BYTES=4, WORDS=512 (AW=9, BW=11).
  logic [8:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic [3:0]  a_wen;
  logic        a_ren, a_rvalid;
  logic        b_load, b_wen, b_ren, b_rvalid, b_wrap;
  logic [10:0] b_load_addr, b_ptr;
  logic [7:0]  b_wdata, b_rdata;
  logic        collision;

  // Small instance: WORD_BYTES=2, WORDS=8 (AW=3, BW=4).
  logic [2:0]  s_a_addr;
  logic [15:0] s_a_wdata, s_a_rdata;
  logic [1:0]  s_a_wen;
  logic        s_a_ren, s_a_rvalid;
  logic        s_b_load, s_b_wen, s_b_ren, s_b_rvalid, s_b_wrap;
  logic [3:0]  s_b_load_addr, s_b_ptr;
  logic [7:0]  s_b_wdata, s_b_rdata;
  logic        s_collision;

  r_asym_stream_buf #(.WORD_BYTES(4), .WORDS(512)) dut (
    .Clk(clk), .Rst_N(rst_n),
    .A_Addr(a_addr), .A_WData(a_wdata), .A_WEn(a_wen), .A_REn(a_ren),
    .A_RData(a_rdata), .A_RValid(a_rvalid),
    .B_Load(b_load), .B_LoadAddr(b_load_addr), .B_WEn(b_wen), .B_WData(b_wdata),
    .B_REn(b_ren), .B_RData(b_rdata), .B_RValid(b_rvalid), .B_Ptr(b_ptr), .B_Wrap(b_wrap)
`ifdef R_ASYM_COLLISION_DET_EN
    , .Collision(collision)
`endif
  );

  r_asym_stream_buf #(.WORD_BYTES(2), .WORDS(8)) dut_small (
    .Clk(clk), .Rst_N(rst_n),
    .A_Addr(s_a_addr), .A_WData(s_a_wdata), .A_WEn(s_a_wen), .A_REn(s_a_ren),
    .A_RData(s_a_rdata), .A_RValid(s_a_rvalid),
    .B_Load(s_b_load), .B_LoadAddr(s_b_load_addr), .B_WEn(s_b_wen), .B_WData(s_b_wdata),
    .B_REn(s_b_ren), .B_RData(s_b_rdata), .B_RValid(s_b_rvalid), .B_Ptr(s_b_ptr),
    .B_Wrap(s_b_wrap)
`ifdef R_ASYM_COLLISION_DET_EN
    , .Collision(s_collision)
`endif
  );

`ifndef R_ASYM_COLLISION_DET_EN
  assign collision   = 1'b0;
  assign s_collision = 1'b0;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    a_addr = '0; a_wdata = '0; a_wen = '0; a_ren = 1'b0;
    b_load = 1'b0; b_load_addr = '0; b_wen = 1'b0; b_wdata = '0; b_ren = 1'b0;
    s_a_addr = '0; s_a_wdata = '0; s_a_wen = '0; s_a_ren = 1'b0;
    s_b_load = 1'b0; s_b_load_addr = '0; s_b_wen = 1'b0; s_b_wdata = '0; s_b_ren = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    // Requests during reset must be ignored.
    a_ren = 1'b1; b_wen = 1'b1; b_ren = 1'b1; s_b_wen = 1'b1;
    tick(); tick();
    n_cmp++; if (b_ptr !== 11'd0) begin n_err++; $display("FAIL rst_ptr: got %0d want 0", b_ptr); end
    n_cmp++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_a_rvalid: got %b want 0", a_rvalid); end
    n_cmp++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_b_rvalid: got %b want 0", b_rvalid); end
    n_cmp++; if (s_b_ptr !== 4'd0) begin n_err++; $display("FAIL rst_s_ptr: got %0d want 0", s_b_ptr); end
    idle_inputs();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (b_wrap !== 1'b0) begin n_err++; $display("FAIL rel_wrap: got %b want 0", b_wrap); end
    n_cmp++; if (a_rdata !== 32'h0) begin n_err++; $display("FAIL rel_a_rdata: got %h want 0", a_rdata); end
    n_cmp++; if (b_rdata !== 8'h0) begin n_err++; $display("FAIL rel_b_rdata: got %h want 0", b_rdata); end
    n_cmp++; if (collision !== 1'b0) begin n_err++; $display("FAIL rel_collision: got %b want 0", collision); end
  endtask

  task automatic test_stream_read;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    a_addr = 9'd5; a_wdata = 32'h4433_2211; a_wen = 4'hF;
    tick();
    a_wen = 4'h0;
    b_load = 1'b1; b_load_addr = 11'd20;
    tick();
    b_load = 1'b0;
    n_cmp++; if (b_ptr !== 11'd20) begin n_err++; $display("FAIL load_ptr: got %0d want 20", b_ptr); end
    b_ren = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      n_cmp++;
      if (b_rvalid !== 1'b1 || b_rdata !== exp_b[j]) begin
        n_err++; $display("FAIL stream_byte%0d: got v=%b %h want v=1 %h", j, b_rvalid, b_rdata, exp_b[j]);
      end
    end
    b_ren = 1'b0;
    n_cmp++; if (b_ptr !== 11'd24) begin n_err++; $display("FAIL stream_ptr: got %0d want 24", b_ptr); end
    tick();
    n_cmp++; if (b_rvalid !== 1'b0 || b_rdata !== 8'h44) begin
      n_err++; $display("FAIL stream_hold: got v=%b %h want v=0 44", b_rvalid, b_rdata); end
    a_ren = 1'b1;
    tick();
    a_ren = 1'b0;
    n_cmp++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h4433_2211) begin
      n_err++; $display("FAIL a_read5: got v=%b %h want v=1 44332211", a_rvalid, a_rdata); end
    tick();
    n_cmp++; if (a_rvalid !== 1'b0 || a_rdata !== 32'h4433_2211) begin
      n_err++; $display("FAIL a_hold: got v=%b %h want v=0 44332211", a_rvalid, a_rdata); end
  endtask

  task automatic test_wrap;
    b_load = 1'b1; b_load_addr = 11'd2047;
    tick();
    b_load = 1'b0; b_wen = 1'b1; b_wdata = 8'hAA;
    tick();
    n_cmp++; if (b_ptr !== 11'd0 || b_wrap !== 1'b1) begin
      n_err++; $display("FAIL wrap_first: got ptr=%0d wrap=%b want ptr=0 wrap=1", b_ptr, b_wrap); end
    b_wdata = 8'hBB;
    tick();
    b_wen = 1'b0;
    n_cmp++; if (b_ptr !== 11'd1 || b_wrap !== 1'b1) begin
      n_err++; $display("FAIL wrap_second: got ptr=%0d wrap=%b want ptr=1 wrap=1", b_ptr, b_wrap); end
    a_addr = 9'd511; a_ren = 1'b1;
    tick();
    n_cmp++; if (a_rdata[31:24] !== 8'hAA) begin
      n_err++; $display("FAIL wrap_w511: got %h want AA", a_rdata[31:24]); end
    a_addr = 9'd0;
    tick();
    a_ren = 1'b0;
    n_cmp++; if (a_rdata[7:0] !== 8'hBB) begin
      n_err++; $display("FAIL wrap_w0: got %h want BB", a_rdata[7:0]); end
    b_load = 1'b1; b_load_addr = 11'd0;
    tick();
    b_load = 1'b0;
    n_cmp++; if (b_wrap !== 1'b0) begin n_err++; $display("FAIL wrap_clear: got %b want 0", b_wrap); end
  endtask

  task automatic test_conflict;
    b_load = 1'b1; b_load_addr = 11'd13;
    tick();
    b_load = 1'b0;
    a_addr = 9'd3; a_wdata = 32'hDEAD_BEEF; a_wen = 4'hF;
    b_wen = 1'b1; b_wdata = 8'h55;
    tick();
    a_wen = 4'h0; b_wen = 1'b0;
    n_cmp++; if (b_ptr !== 11'd14) begin n_err++; $display("FAIL ww_ptr: got %0d want 14", b_ptr); end
`ifdef R_ASYM_COLLISION_DET_EN
    n_cmp++; if (collision !== 1'b1) begin n_err++; $display("FAIL ww_collision: got %b want 1", collision); end
`endif
    a_ren = 1'b1;
    tick();
    n_cmp++; if (a_rdata !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL ww_data: got %h want DEADBEEF", a_rdata); end
    n_cmp++; if (collision !== 1'b0) begin n_err++; $display("FAIL ww_pulse: got %b want 0", collision); end
    // Read-before-write on port A.
    a_wen = 4'hF; a_wdata = 32'h0102_0304;
    tick();
    a_wen = 4'h0;
    n_cmp++; if (a_rdata !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL a_rbw_old: got %h want DEADBEEF", a_rdata); end
    tick();
    a_ren = 1'b0;
    n_cmp++; if (a_rdata !== 32'h0102_0304) begin
      n_err++; $display("FAIL a_rbw_new: got %h want 01020304", a_rdata); end
    // B reads byte 12 while A writes it: B sees old data.
    b_load = 1'b1; b_load_addr = 11'd12;
    tick();
    b_load = 1'b0; b_ren = 1'b1;
    a_wen = 4'h1; a_wdata = 32'h0000_0099;
    tick();
    b_ren = 1'b0; a_wen = 4'h0;
    n_cmp++; if (b_rvalid !== 1'b1 || b_rdata !== 8'h04) begin
      n_err++; $display("FAIL b_rbw: got v=%b %h want v=1 04", b_rvalid, b_rdata); end
`ifdef R_ASYM_COLLISION_DET_EN
    n_cmp++; if (collision !== 1'b1) begin n_err++; $display("FAIL rw_collision: got %b want 1", collision); end
`endif
    a_ren = 1'b1;
    tick();
    a_ren = 1'b0;
    n_cmp++; if (a_rdata !== 32'h0102_0399) begin
      n_err++; $display("FAIL a_lane_wr: got %h want 01020399", a_rdata); end
  endtask

  task automatic test_priority;
    a_addr = 9'd10; a_wdata = 32'hCAFE_F00D; a_wen = 4'hF;
    tick();
    a_wen = 4'h0;
    b_load = 1'b1; b_load_addr = 11'd40; b_wen = 1'b1; b_wdata = 8'h77; b_ren = 1'b1;
    tick();
    b_load = 1'b0; b_wen = 1'b0;
    n_cmp++; if (b_ptr !== 11'd40 || b_rvalid !== 1'b0) begin
      n_err++; $display("FAIL prio_load: got ptr=%0d v=%b want ptr=40 v=0", b_ptr, b_rvalid); end
    tick();
    n_cmp++; if (b_rvalid !== 1'b1 || b_rdata !== 8'h0D || b_ptr !== 11'd41) begin
      n_err++; $display("FAIL prio_nowrite: got v=%b %h ptr=%0d want v=1 0D ptr=41", b_rvalid, b_rdata, b_ptr); end
    b_wen = 1'b1; b_wdata = 8'h66;
    tick();
    b_wen = 1'b0; b_ren = 1'b0;
    n_cmp++; if (b_rvalid !== 1'b0 || b_ptr !== 11'd42) begin
      n_err++; $display("FAIL prio_wr_over_rd: got v=%b ptr=%0d want v=0 ptr=42", b_rvalid, b_ptr); end
    a_ren = 1'b1;
    tick();
    a_ren = 1'b0;
    n_cmp++; if (a_rdata !== 32'hCAFE_660D) begin
      n_err++; $display("FAIL prio_word: got %h want CAFE660D", a_rdata); end
  endtask

  task automatic test_small_fill;
    logic [15:0] exp_w;
    logic [7:0]  exp_b;
    s_b_load = 1'b1; s_b_load_addr = 4'd0;
    tick();
    s_b_load = 1'b0; s_b_wen = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_b_wdata = 8'(i);
      tick();
      if (i == 14) begin
        n_cmp++; if (s_b_wrap !== 1'b0 || s_b_ptr !== 4'd15) begin
          n_err++; $display("FAIL small_pre_wrap: got ptr=%0d wrap=%b want ptr=15 wrap=0", s_b_ptr, s_b_wrap); end
      end
    end
    s_b_wen = 1'b0;
    n_cmp++; if (s_b_wrap !== 1'b1 || s_b_ptr !== 4'd0) begin
      n_err++; $display("FAIL small_wrap: got ptr=%0d wrap=%b want ptr=0 wrap=1", s_b_ptr, s_b_wrap); end
    s_a_ren = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s_a_addr = 3'(k);
      tick();
      exp_w = {8'(2*k+1), 8'(2*k)};
      n_cmp++; if (s_a_rvalid !== 1'b1 || s_a_rdata !== exp_w) begin
        n_err++; $display("FAIL small_word%0d: got v=%b %h want v=1 %h", k, s_a_rvalid, s_a_rdata, exp_w); end
    end
    s_a_ren = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b;
    s_b_load = 1'b1; s_b_load_addr = 4'd14;
    tick();
    s_b_load = 1'b0; s_b_ren = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      exp_b = 8'((14 + j) % 16);
      n_cmp++; if (s_b_rvalid !== 1'b1 || s_b_rdata !== exp_b) begin
        n_err++; $display("FAIL b2b_byte%0d: got v=%b %h want v=1 %h", j, s_b_rvalid, s_b_rdata, exp_b); end
    end
    s_b_ren = 1'b0;
    n_cmp++; if (s_b_ptr !== 4'd2 || s_b_wrap !== 1'b1) begin
      n_err++; $display("FAIL b2b_ptr: got ptr=%0d wrap=%b want ptr=2 wrap=1", s_b_ptr, s_b_wrap); end
  endtask

  task automatic test_reset_mid;
    b_ren = 1'b1;
    tick();
    rst_n = 1'b0;
    b_ren = 1'b0;
    #1;
    n_cmp++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_rvalid: got %b want 0", b_rvalid); end
    tick();
    n_cmp++; if (b_ptr !== 11'd0 || b_wrap !== 1'b0) begin
      n_err++; $display("FAIL mid_ptr: got ptr=%0d wrap=%b want 0 0", b_ptr, b_wrap); end
    n_cmp++; if (s_b_wrap !== 1'b0 || s_b_ptr !== 4'd0) begin
      n_err++; $display("FAIL mid_small: got ptr=%0d wrap=%b want 0 0", s_b_ptr, s_b_wrap); end
    n_cmp++; if (b_rdata !== 8'h0 || a_rdata !== 32'h0) begin
      n_err++; $display("FAIL mid_rdata: got b=%h a=%h want 0 0", b_rdata, a_rdata); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (b_rvalid !== 1'b0 || b_ptr !== 11'd0) begin
      n_err++; $display("FAIL mid_release: got v=%b ptr=%0d want 0 0", b_rvalid, b_ptr); end
  endtask

  initial begin
    test_reset();
    test_stream_read();
    test_wrap();
    test_conflict();
    test_priority();
    test_small_fill();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/r_asym_stream_buf.md
# r_asym_stream_buf

Parametrised asymmetric dual-port buffer with a random-access word port (A) and an auto-incrementing byte-stream port (B), both in one clock domain.
- Port A serves the host-side bus.
- Port B serves the byte-serial protocol engine (TPM FIFO/CRB data path), so the engine never has to compute byte addresses.
- Generalises the fixed 512x32/2048x8 split to any power-of-two word width and depth.
- Adds pointer management, read handshakes, wrap tracking and deterministic same-cycle arbitration.

## Interface
Parameters:
- WORD_BYTES, 4, bytes per port-A word; power of two, 1..8
- WORDS, 512, port-A depth; power of two, >=2
- Derived: AW = log2(WORDS); BW = AW + log2(WORD_BYTES)

Ports:
- Clk  in  1  single clock
- Rst_N  in  1  synchronous, active-low reset
- A_Addr  in  AW  word address
- A_WData  in  8*WORD_BYTES  write data; lane i = bits 8i+7:8i
- A_WEn  in  WORD_BYTES  per-byte write enables
- A_REn  in  1  read request
- A_RData  out  8*WORD_BYTES  read data
- A_RValid  out  1  A_RData valid
- B_Load  in  1  load pointer from B_LoadAddr
- B_LoadAddr  in  BW  new byte pointer
- B_WEn  in  1  write B_WData at pointer, then increment
- B_WData  in  8  byte write data
- B_REn  in  1  read byte at pointer, then increment
- B_RData  out  8  byte read data
- B_RValid  out  1  B_RData valid
- B_Ptr  out  BW  current byte pointer
- B_Wrap  out  1  sticky: pointer wrapped since last load/reset
- Collision  out  1  present only with R_ASYM_COLLISION_DET_EN

## Operation
- Byte mapping: byte address p maps to word p[BW-1:log2(WORD_BYTES)], lane p[log2(WORD_BYTES)-1:0]. Lane 0 is the least significant byte.
- Port A:
  - Writes the enabled lanes at A_Addr.
  - A_REn returns the full word.
  - A read and write to the same address in the same cycle return the old data (read-before-write).
- Port B pointer priority per cycle:
  - B_Load > B_WEn > B_REn.
  - B_Load: B_Ptr <= B_LoadAddr, B_Wrap <= 0; any B_WEn/B_REn in that cycle is ignored.
  - B_WEn with B_REn: write only; the read is dropped and B_RValid stays 0 next cycle.
  - Each accepted B_WEn or B_REn increments B_Ptr by 1, modulo 2^BW.
  - On the increment from 2^BW-1 to 0, B_Wrap <= 1. It stays set until B_Load or reset.
- Cross-port conflicts in the same cycle:
  - A write and B write to the same byte: port A data is stored; the B write to that byte is discarded. The pointer still increments.
  - A read of a byte being written by B, or B read of a byte being written by A: the reader gets the old data.
- RAM contents are not reset and are undefined after power-up.

## Timing
- A read latency: 1 cycle. A_RValid = registered A_REn; A_RData holds until the next accepted read.
- B read latency: 1 cycle. B_RValid = registered accepted B_REn; B_RData holds until the next accepted read.
- Back-to-back B_REn every cycle streams one byte per cycle with no bubbles, including across word boundaries and the wrap.
- B_Ptr and B_Wrap update on the clock edge that accepts the operation; the new values are visible the next cycle.
- Values during Rst_N=0 and in the cycle after release:
  - A_RValid, B_RValid, B_Ptr, B_Wrap and Collision are all 0.
  - A_RData and B_RData are 0.
  - Requests presented while Rst_N=0 are ignored.
- Reset mid-operation: a read issued in the cycle before reset does not produce a valid.

## Configuration
- R_ASYM_COLLISION_DET_EN defined:
  - Collision pulses high for one cycle, in the cycle after a same-cycle, same-byte conflict between the ports.
  - A conflict is a write on both ports, or a write on one port and a read on the other.
  - Collision is reset to 0.
- Not defined:
  - The Collision port does not exist and no detection logic is built.
  - Arbitration is unchanged.

## Structure
- Package r_asym_pkg holds:
  - width-derivation functions (clog2-based AW/BW)
  - lane-select helper for byte-address to word/lane split
  - the B operation priority encoding constant
- Sub-module r_asym_lane:
  - One 8-bit-wide, WORDS-deep bank, instantiated WORD_BYTES times.
  - Word-side port: A_Addr, lane write enable, lane data.
  - Byte-side port: word index, lane-match write enable.
  - Maps to one DP16KD per lane for WORDS <= 2048.
- Top level holds the pointer, wrap flag, valid pipeline, lane read mux, conflict masking and the optional Collision logic.

## Test plan
- Defaults: A writes 0x44332211 to word 5 with A_WEn=1111; B_Load 20; four B_REn -> B_RData 0x11, 0x22, 0x33, 0x44 on consecutive cycles; B_Ptr=24.
- B_Load 2047; B_WEn 0xAA then 0xBB -> B_Ptr=1, B_Wrap=1; A reads word 511 -> byte 3 = 0xAA; A reads word 0 -> byte 0 = 0xBB.
- Same cycle: A writes word 3 = 0xDEADBEEF (WEn=1111) and B writes 0x55 at byte 13 -> word 3 reads 0xDEADBEEF; Collision=1 one cycle later (macro on).
- B_Load, B_WEn and B_REn asserted together -> B_Ptr = load value; no write; B_RValid=0 next cycle.
- WORD_BYTES=2, WORDS=8: B writes 0..15 sequentially -> A reads word k = {2k+1, 2k}; B_Wrap=1 after the 16th write.
- Assert Rst_N=0 the cycle after B_REn -> B_RValid stays 0; B_Ptr=0; B_Wrap=0.
